data_sram_responder: RTL

- Slave-side (responder) end of the SRAM-like data interface that the MEM stage consumes. Core drives req/wr/size/addr/wstrb/wdata; this block returns addr_ok, data_ok and rdata.
- Backs the interface with an internal word-wide memory.
- Queues accepted requests in order and returns each response after a programmable latency.
- Used as the data-side memory in core-level simulation and FPGA bring-up. Exercises the MEM stage's wait/data-buffer logic.

---
 rtl/data_sram_responder.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/data_sram_responder.sv
// data_sram_responder: responder side of the SRAM-like data interface.
// Accepted requests go into an in-order FIFO. Each request is answered with a
// single data_ok pulse once its countdown has expired and it has reached the head.
// Writes are committed to the internal word memory on the same edge that pops them.
// Optional build macro: RSP_LFSR_DELAY_EN adds 0..3 cycles of LFSR jitter to each
// request's latency.
module data_sram_responder #(
    parameter int ADDR_W = 10,
    parameter int DEPTH  = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        data_sram_req,
    input  logic        data_sram_wr,
    input  logic [1:0]  data_sram_size,
    input  logic [31:0] data_sram_addr,
    input  logic [3:0]  data_sram_wstrb,
    input  logic [31:0] data_sram_wdata,
    output logic        data_sram_addr_ok,
    output logic        data_sram_data_ok,
    output logic [31:0] data_sram_rdata,
    input  logic [3:0]  cfg_rsp_delay
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int WORDS = 1 << ADDR_W;

    typedef struct packed {
        logic              wr;
        logic [ADDR_W-1:0] idx;
        logic [3:0]        wstrb;
        logic [31:0]       wdata;
        logic [4:0]        cnt;
    } entry_t;

    entry_t           q_reg [DEPTH];
    entry_t           head_entry;
    logic [PTR_W-1:0] head_reg, head_next;
    logic [PTR_W-1:0] tail_reg, tail_next;
    logic [CNT_W-1:0] count_reg, count_next;
    logic             push;
    logic             pop;
    logic [4:0]       new_delay;
    logic [3:0][7:0]  rd_bytes;

    // Size and the aliased address bits do not affect behaviour; lanes come from wstrb.
    logic unused_inputs;
    assign unused_inputs = ^{data_sram_size, data_sram_addr[31:ADDR_W+2], data_sram_addr[1:0]};

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(DEPTH - 1)) begin
            return '0;
        end
        return p + 1'b1;
    endfunction

`ifdef RSP_LFSR_DELAY_EN
    logic [15:0] lfsr_reg;

    // Fibonacci LFSR, taps 16/14/13/11, stepping every cycle to jitter latencies.
    always_ff @(posedge clk) begin
        if (reset) begin
            lfsr_reg <= 16'hACE1;
        end else begin
            lfsr_reg <= {lfsr_reg[14:0], lfsr_reg[15] ^ lfsr_reg[13] ^ lfsr_reg[12] ^ lfsr_reg[10]};
        end
    end

    assign new_delay = {1'b0, cfg_rsp_delay} + {3'b000, lfsr_reg[1:0]};
`else
    assign new_delay = {1'b0, cfg_rsp_delay};
`endif

    // Handshake outputs depend only on registered state; req never reaches addr_ok.
    assign head_entry        = q_reg[head_reg];
    assign data_sram_addr_ok = (count_reg != CNT_W'(DEPTH));
    assign data_sram_data_ok = (count_reg != '0) && (head_entry.cnt == 5'd0);
    assign push              = data_sram_req & data_sram_addr_ok;
    assign pop               = data_sram_data_ok;
    assign data_sram_rdata   = (data_sram_data_ok && !head_entry.wr) ? rd_bytes : 32'h0;

    // Next pointer and occupancy values from this cycle's push/pop.
    always_comb begin
        head_next  = head_reg;
        tail_next  = tail_reg;
        count_next = count_reg;
        if (push) begin
            tail_next = ptr_inc(tail_reg);
        end
        if (pop) begin
            head_next = ptr_inc(head_reg);
        end
        if (push && !pop) begin
            count_next = count_reg + 1'b1;
        end else if (pop && !push) begin
            count_next = count_reg - 1'b1;
        end
    end

    // Queue bookkeeping; reset discards every pending entry.
    always_ff @(posedge clk) begin
        if (reset) begin
            head_reg  <= '0;
            tail_reg  <= '0;
            count_reg <= '0;
        end else begin
            head_reg  <= head_next;
            tail_reg  <= tail_next;
            count_reg <= count_next;
        end
    end

    // Entry payload: load at the tail on accept, otherwise count down towards 0.
    // A free tail slot is never the head being popped, so the two cannot collide.
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (push && (tail_reg == PTR_W'(i))) begin
                q_reg[i].wr    <= data_sram_wr;
                q_reg[i].idx   <= data_sram_addr[ADDR_W+1:2];
                q_reg[i].wstrb <= data_sram_wstrb;
                q_reg[i].wdata <= data_sram_wdata;
                q_reg[i].cnt   <= new_delay;
            end else if (q_reg[i].cnt != 5'd0) begin
                q_reg[i].cnt <= q_reg[i].cnt - 5'd1;
            end
        end
    end

    // One byte-wide memory per lane; writes commit only when the write is popped.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            logic [7:0] mem_lane [WORDS];

            // Lane commit on pop of a write with this strobe set; reset blocks the commit.
            always_ff @(posedge clk) begin
                if (!reset && pop && head_entry.wr && head_entry.wstrb[gi]) begin
                    mem_lane[head_entry.idx] <= head_entry.wdata[8*gi +: 8];
                end
            end

            assign rd_bytes[gi] = mem_lane[head_entry.idx];
        end
    endgenerate

endmodule
